multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle controller for the RV32I DataPath: decodes instrCode and sequences
//  FETCH/DECODE/EXECUTE/MEM/WB, driving PCEn, regFileWe, aluControl, mux selects and
//  branch/jal/jalr. Owns the data-bus request handshake with wait states.
//  Flags illegal opcodes and bus timeouts. Sits beside DataPath inside the CPU top.
// PARAMETERS
//  BUS_TIMEOUT  16  max MEM-state wait cycles before busErr; 0 = wait forever
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  instrCode      in   32  current instruction (instr memory at PC)
//  PCEn           out  1   PC load enable
//  regFileWe      out  1   register file write enable
//  aluControl     out  4   ALU op / branch condition (defines.sv encodings)
//  aluSrcMuxSel   out  1   0 = RD2, 1 = immExt
//  RFWDSrcMuxSel  out  3   0 alu, 1 mem, 2 imm, 3 PC+imm, 4 PC+4
//  branch,jal,jalr out 1 each  PC-source controls
//  busReq         out  1   data-bus access request
//  busWe          out  1   1 = store, 0 = load; valid while busReq=1
//  busReady       in   1   bus completes access this cycle
//  illegalInstr   out  1   sticky; unknown opcode seen
//  busErr         out  1   sticky; BUS_TIMEOUT exceeded
// BEHAVIOUR
//  - Reset (reset=0): state=FETCH, all outputs 0, sticky flags cleared, timer=0.
//  - FETCH: PCEn=1 (PC <= ExeReg_PCSrcMux). FETCH -> DECODE, unconditional.
//  - DECODE: no side effects. DECODE -> EXECUTE on a legal opcode, else -> HALT.
//  - EXECUTE: mux and ALU controls per opcode.
//    R/I/LU/AU/J/JL: regFileWe=1 -> FETCH.
//    B: branch=1 -> FETCH. S/L: aluSrcMuxSel=1, ADD -> MEM.
//  - MEM: busReq=1, busWe=(S). Holds until busReady=1.
//    S -> FETCH; L -> WB. A busReady outside MEM is ignored.
//  - WB (load only): regFileWe=1, RFWDSrcMuxSel=1 -> FETCH.
//  - HALT: illegalInstr=1, all strobes 0; exits only on reset.
//  - Timeout: timer counts MEM cycles with busReady=0.
//    At BUS_TIMEOUT it sets busErr, drops busReq and goes to HALT.
//  - Latency in cycles: R/I/B/J = 3; S = 4 + waits; L = 5 + waits.
//  - aluControl:
//    R: {f7[5], f3}. I: {f3==101 ? f7[5] : 0, f3}.
//    B: {0, f3}. All other opcodes: ADD.
//  - aluSrcMuxSel=1 for I/L/S/JL.
//  - RFWDSrcMuxSel: LU=2, AU=3, J/JL=4, L=1 (WB only), otherwise 0.
//  - jal=1 for J and JL; jalr=1 for JL; both asserted only in EXECUTE.
//  - Controls held at 0 outside their asserting state (no X on any output).
//  - Reset mid-instruction aborts immediately. No bus or RF write completes after reset falls.
//  - Timer is 8 bits wide; BUS_TIMEOUT > 255 is illegal (static assert).
// STRUCTURE
//  - Shared package cu_pkg: state_e enum {FETCH, DECODE, EXECUTE, MEM, WB, HALT}
//    and the RFWD select constants. Opcodes and ALU codes come from defines.sv.
//  - One sub-module, instr_decoder: combinational opcode/func decode to a control
//    bundle plus a legal bit. The FSM and the timer live in the top module.
// TESTING
//  1. add x3,x1,x2 (0x002081B3), busReady=0 -> PCEn in cycle 0.
//     regFileWe=1 only in cycle 2 with aluControl=0000, sel=0; back to FETCH in cycle 3.
//  2. sub x3,x1,x2 -> aluControl=1000. srai x3,x1,2 -> aluControl=1101, aluSrcMuxSel=1.
//  3. lw x5,4(x1), busReady after 3 waits -> busReq high 4 cycles, busWe=0.
//     Then WB has regFileWe=1, sel=1; 8 cycles total.
//  4. sw x2,8(x1), busReady=1 at once -> MEM 1 cycle, busWe=1, regFileWe never 1.
//  5. beq (f3=000) -> EXECUTE: branch=1, aluControl=0000, regFileWe=0.
//     jalr -> jal=1, jalr=1, sel=4.
//  6. Opcode 0x7F -> HALT, illegalInstr=1.
//     Load with busReady=0 for 16 cycles -> busErr=1.
//     reset=0 mid-MEM -> busReq=0 same cycle, FETCH after release.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package cu_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_e;

  // Register-file write-data source selects
  localparam logic [2:0] RFWD_ALU    = 3'd0;
  localparam logic [2:0] RFWD_MEM    = 3'd1;
  localparam logic [2:0] RFWD_IMM    = 3'd2;
  localparam logic [2:0] RFWD_PC_IMM = 3'd3;
  localparam logic [2:0] RFWD_PC4    = 3'd4;

  // RV32I major opcodes
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  // Decoded control bundle for the EXECUTE / MEM states
  typedef struct packed {
    logic       legal;
    logic       reg_we;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic [2:0] rfwd_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       is_mem;
    logic       is_store;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode/funct decode into the control bundle.
module instr_decoder
  import cu_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7_5;
  logic       unused_bits;

  assign opcode      = instr[6:0];
  assign f3          = instr[14:12];
  assign f7_5        = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Decode opcode into control fields; unknown opcodes leave legal=0
  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R: begin
        ctrl.legal    = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.alu_ctrl = {f7_5, f3};
      end
      OP_I: begin
        ctrl.legal    = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.alu_src  = 1'b1;
        // Only shift-right immediates use f7[5] (SRLI vs SRAI)
        ctrl.alu_ctrl = {(f3 == 3'b101) ? f7_5 : 1'b0, f3};
      end
      OP_L: begin
        ctrl.legal   = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.is_mem  = 1'b1;
      end
      OP_S: begin
        ctrl.legal    = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.is_mem   = 1'b1;
        ctrl.is_store = 1'b1;
      end
      OP_B: begin
        ctrl.legal    = 1'b1;
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = {1'b0, f3};
      end
      OP_LU: begin
        ctrl.legal    = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.rfwd_sel = RFWD_IMM;
      end
      OP_AU: begin
        ctrl.legal    = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.rfwd_sel = RFWD_PC_IMM;
      end
      OP_J: begin
        ctrl.legal    = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.rfwd_sel = RFWD_PC4;
      end
      OP_JL: begin
        ctrl.legal    = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.alu_src  = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.jalr     = 1'b1;
        ctrl.rfwd_sel = RFWD_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: FSM, data-bus handshake with timeout, sticky error flags.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busReq,
  output logic        busWe,
  input  logic        busReady,
  output logic        illegalInstr,
  output logic        busErr
);

  if (BUS_TIMEOUT > 255) begin : g_timeout_check
    $error("BUS_TIMEOUT must fit the 8-bit wait timer");
  end

  // Timer value on the final permitted wait cycle
  localparam logic [7:0] TimeoutLast = 8'(BUS_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  ctrl_t      ctrl;

  // instrCode is assumed stable from DECODE until the next FETCH
  instr_decoder u_decoder (
    .instr (instrCode),
    .ctrl  (ctrl)
  );

  // State, wait timer and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      timer_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic and per-state control strobes
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = '0;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;

    case (state_q)
      FETCH: begin
        PCEn    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (ctrl.legal) begin
          state_d = EXECUTE;
        end else begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end
      end
      EXECUTE: begin
        regFileWe     = ctrl.reg_we;
        aluControl    = ctrl.alu_ctrl;
        aluSrcMuxSel  = ctrl.alu_src;
        RFWDSrcMuxSel = ctrl.rfwd_sel;
        branch        = ctrl.branch;
        jal           = ctrl.jal;
        jalr          = ctrl.jalr;
        timer_d       = '0;
        state_d       = ctrl.is_mem ? MEM : FETCH;
      end
      MEM: begin
        busReq = 1'b1;
        busWe  = ctrl.is_store;
        if (busReady) begin
          timer_d = '0;
          state_d = ctrl.is_store ? FETCH : WB;
        end else if ((BUS_TIMEOUT != 0) && (timer_q == TimeoutLast)) begin
          timer_d   = '0;
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      WB: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_MEM;
        state_d       = FETCH;
      end
      HALT: ;
      default: state_d = FETCH;
    endcase

    // Strobes drop the moment reset asserts, not at the next edge
    if (!reset) begin
      PCEn          = 1'b0;
      regFileWe     = 1'b0;
      aluControl    = '0;
      aluSrcMuxSel  = 1'b0;
      RFWDSrcMuxSel = RFWD_ALU;
      branch        = 1'b0;
      jal           = 1'b0;
      jalr          = 1'b0;
      busReq        = 1'b0;
      busWe         = 1'b0;
    end
  end

  assign illegalInstr = illegal_q;
  assign busErr       = bus_err_q;

endmodule
